// File: rtl/add_accum_16bit.sv
// Multi-cycle 16-bit accumulator: sums `len` streamed operands and reports
// the low 16 bits of the total plus a saturating count of carry-outs.
module add_accum_16bit #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] carries_q, carries_d;
  logic [16:0]      sum_ext;

  assign sum_ext = {1'b0, acc_q} + {1'b0, in_data};

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    carries_d = carries_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d     = '0;
          carries_d = '0;
          if (len != '0) begin
            rem_d   = len;
            state_d = ACC;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d = sum_ext[15:0];
          // Carry count saturates instead of wrapping.
          if (sum_ext[16] && (carries_q != '1)) begin
            carries_d = carries_q + CNT_W'(1);
          end
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      acc_q     <= '0;
      carries_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      carries_q <= carries_d;
    end
  end

  assign in_ready    = (state_q == ACC);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign out_sum     = acc_q;
  assign out_carries = carries_q;

endmodule

// File: tb/tb_add_accum_16bit.sv
// Self-checking bench for add_accum_16bit: table-driven vectors with a
// result scoreboard, plus hand sequences for CNT_W=2 and async reset.
module tb_add_accum_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic [7:0]  out_carries;
  logic        busy;

  logic        s_start = 1'b0;
  logic [1:0]  s_len = '0;
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [15:0] s_in_data = '0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [15:0] s_out_sum;
  logic [1:0]  s_out_carries;
  logic        s_busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0]  len;
    logic [15:0] d0;
    logic [15:0] inc;
    bit          gap;
    int          hold;
    logic [15:0] exp_sum;
    logic [7:0]  exp_car;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic [7:0]  car;
  } res_t;

  res_t sb_q[$];

  add_accum_16bit #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carries(out_carries), .busy(busy)
  );

  add_accum_16bit #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .len(s_len),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum),
    .out_carries(s_out_carries), .busy(s_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: one pop per presented result, then stability while held.
  bit   mon_seen = 1'b0;
  res_t mon_held;
  always @(negedge clk) begin
    if (out_valid) begin
      if (!mon_seen) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          mon_held = sb_q.pop_front();
          chk("sb_sum", 32'(out_sum), 32'(mon_held.sum));
          chk("sb_carries", 32'(out_carries), 32'(mon_held.car));
        end
        mon_seen = 1'b1;
      end else begin
        chk("sb_hold_sum", 32'(out_sum), 32'(mon_held.sum));
        chk("sb_hold_carries", 32'(out_carries), 32'(mon_held.car));
      end
    end else begin
      mon_seen = 1'b0;
    end
  end

  // Entered and left on a falling edge so the next start is back-to-back.
  task automatic run_vec(input vec_t v);
    int   i;
    int   cyc;
    bit   tog;
    res_t r;
    start = 1'b1;
    len = v.len;
    r.sum = v.exp_sum;
    r.car = v.exp_car;
    sb_q.push_back(r);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    i = 0; cyc = 0; tog = 1'b0;
    while (i < int'(v.len)) begin
      if (cyc >= 2000) begin
        chk("beat_timeout", 32'(i), 32'(v.len));
        break;
      end
      if (v.gap && tog) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data = v.d0 + 16'(i) * v.inc;
      end
      tog = ~tog;
      if (in_valid && in_ready) i++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    if (v.len == '0) chk("len0_in_ready", 32'(in_ready), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(out_sum), 32'(v.exp_sum));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("retain_sum", 32'(out_sum), 32'(v.exp_sum));
    chk("retain_carries", 32'(out_carries), 32'(v.exp_car));
  endtask

  initial begin
    vec_t vecs[6];
    int   i;
    int   cyc;
    vecs[0] = '{len: 8'd3,   d0: 16'h0001, inc: 16'h0001, gap: 1'b0, hold: 0, exp_sum: 16'h0006, exp_car: 8'd0};
    vecs[1] = '{len: 8'd2,   d0: 16'hFFFF, inc: 16'h0003, gap: 1'b0, hold: 1, exp_sum: 16'h0001, exp_car: 8'd1};
    vecs[2] = '{len: 8'd0,   d0: 16'h1234, inc: 16'h0000, gap: 1'b0, hold: 0, exp_sum: 16'h0000, exp_car: 8'd0};
    vecs[3] = '{len: 8'd4,   d0: 16'h1000, inc: 16'h0000, gap: 1'b1, hold: 5, exp_sum: 16'h4000, exp_car: 8'd0};
    vecs[4] = '{len: 8'd5,   d0: 16'h8000, inc: 16'h0000, gap: 1'b0, hold: 2, exp_sum: 16'h8000, exp_car: 8'd2};
    vecs[5] = '{len: 8'd255, d0: 16'hFFFF, inc: 16'h0000, gap: 1'b0, hold: 0, exp_sum: 16'hFF01, exp_car: 8'd254};

    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_carries", 32'(out_carries), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) run_vec(vecs[k]);

    // CNT_W=2: three 0xFFFF beats, second pass with a stray start during ACC.
    for (int pass = 0; pass < 2; pass++) begin
      s_start = 1'b1;
      s_len = 2'd3;
      @(negedge clk);
      s_start = 1'b0;
      i = 0; cyc = 0;
      while (i < 3 && cyc < 100) begin
        s_in_valid = 1'b1;
        s_in_data = 16'hFFFF;
        if (pass == 1 && i == 1) begin
          s_start = 1'b1;
          s_len = 2'd1;
        end else begin
          s_start = 1'b0;
        end
        if (s_in_ready) i++;
        @(negedge clk);
        cyc++;
      end
      s_start = 1'b0;
      s_in_valid = 1'b0;
      chk("w2_beats", 32'(i), 32'd3);
      chk("w2_out_valid", 32'(s_out_valid), 32'd1);
      chk("w2_sum", 32'(s_out_sum), 32'hFFFD);
      chk("w2_carries", 32'(s_out_carries), 32'd2);
      s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
      chk("w2_idle", 32'(s_busy), 32'd0);
    end

    // Async reset after the 2nd of 4 operands.
    start = 1'b1;
    len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    i = 0; cyc = 0;
    while (i < 2 && cyc < 100) begin
      in_valid = 1'b1;
      in_data = 16'h1111;
      if (in_ready) i++;
      if (i < 2) begin
        @(negedge clk);
        cyc++;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("pre_rst_sum", 32'(out_sum), 32'h2222);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_sum", 32'(out_sum), 32'd0);
    chk("arst_carries", 32'(out_carries), 32'd0);
    #4 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd0);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    run_vec('{len: 8'd1, d0: 16'h00AA, inc: 16'h0000, gap: 1'b0, hold: 1, exp_sum: 16'h00AA, exp_car: 8'd0});

    @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/add_accum_16bit.md
ADD_ACCUM_16BIT -- requirements
Module: add_accum_16bit

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the operand-count and carry-count fields.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a new accumulation.
REQ-005 SHALL have port len  input  CNT_W  number of operands to sum, sampled when start is accepted.
REQ-006 SHALL have port in_valid  input  1  in_data holds a valid operand.
REQ-007 SHALL have port in_ready  output  1  block accepts an operand this cycle.
REQ-008 SHALL have port in_data  input  16  unsigned operand.
REQ-009 SHALL have port out_valid  output  1  result is valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port out_sum  output  16  low 16 bits of the total.
REQ-012 SHALL have port out_carries  output  CNT_W  count of carry-outs produced during accumulation, saturating.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, ACC and DONE.
REQ-015 In IDLE, start=1 with len!=0 SHALL latch len into the remaining count, clear the accumulator and carry count, and move to ACC.
REQ-016 In IDLE, start=1 with len==0 SHALL clear the accumulator and carry count and move directly to DONE.
REQ-017 start SHALL be ignored in ACC and DONE.
REQ-018 in_ready SHALL be 1 only in ACC; an operand is accepted on a clk edge where in_valid=1 and in_ready=1.
REQ-019 On each accepted operand, the accumulator SHALL load (acc + in_data) mod 2^16 as a 16-bit add with carry-in 0, and the remaining count SHALL decrement by 1.
REQ-020 When that add produces carry-out=1, the carry count SHALL increment by 1 and hold at 2^CNT_W-1 (no wrap).
REQ-021 Accepting the operand that brings the remaining count to 0 SHALL move the FSM to DONE.
REQ-022 out_valid SHALL be 1 on the cycle after that last acceptance (latency 1 cycle).
REQ-023 In DONE, out_valid SHALL be 1 and out_sum and out_carries SHALL hold stable until out_ready=1.
REQ-024 A clk edge in DONE with out_ready=1 SHALL return the FSM to IDLE with out_valid=0.
REQ-025 out_sum and out_carries SHALL retain the last result in IDLE and SHALL be cleared only on start acceptance or reset.
REQ-026 in_valid=0 in ACC SHALL stall the FSM with no state change; there is no timeout.
REQ-027 len=2^CNT_W-1 SHALL accept exactly 2^CNT_W-1 operands.
REQ-028 Back-to-back operation SHALL be supported: start may be accepted in the cycle after the DONE->IDLE handshake.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force: state IDLE, in_ready=0, out_valid=0, busy=0, out_sum=0, out_carries=0, remaining count=0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation; no result is presented after rst_n returns to 1.
REQ-031 After rst_n deasserts, the first clk edge SHALL be able to accept start.

Verification
REQ-032 len=3, operands 0x0001, 0x0002, 0x0003 sent with no gaps -> out_sum=0x0006, out_carries=0, out_valid high 1 cycle after the 3rd beat.
REQ-033 len=2, operands 0xFFFF then 0x0002 -> out_sum=0x0001, out_carries=1.
REQ-034 len=0 -> out_valid=1 on the next cycle with out_sum=0, out_carries=0, and in_ready never asserted.
REQ-035 len=4, operands 0x1000 each, in_valid toggled every other cycle, out_ready held low 5 cycles -> out_sum=0x4000, held stable until out_ready, then IDLE.
REQ-036 CNT_W=2, len=3, operands 0xFFFF x3 -> out_sum=0xFFFD, out_carries=2; the same run with a start pulse during ACC is ignored.
REQ-037 rst_n pulsed low asynchronously between clk edges after the 2nd of 4 operands -> outputs cleared at once, busy=0, and a later len=1, operand 0x00AA -> out_sum=0x00AA.
